// File: rtl/decoder_rr_scheduler.sv
// rtl/decoder_rr_scheduler.sv - round-robin burst scheduler driving a shared select/enable decoder
// Grants are bounded to MAX_HOLD cycles and separated by GAP_CYCLES cycles of en low.
module decoder_rr_scheduler #(
    parameter int SEL_W      = 3,
    parameter int MAX_HOLD   = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arb_en,
    input  logic [2**SEL_W-1:0]   req,
    output logic [SEL_W-1:0]      sel,
    output logic                  en,
    output logic [2**SEL_W-1:0]   grant,
    output logic                  busy
);
    localparam int N      = 2**SEL_W;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   last;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [SEL_W-1:0]   winner;
    logic [SEL_W-1:0]   scan;
    logic               win_valid;
    logic [N-1:0]       win_onehot;

    // Scan from farthest (last itself) to nearest (last+1) so the nearest set request
    // overwrites; last only survives when it is the sole requester.
    always_comb begin
        winner = last;
        scan   = last;
        for (int k = N; k >= 1; k--) begin
            scan = last + SEL_W'(k);
            if (req[scan]) begin
                winner = scan;
            end
        end
    end

    assign win_valid  = arb_en && (|req);
    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << winner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            en       <= 1'b0;
            grant    <= '0;
            busy     <= 1'b0;
            last     <= SEL_W'(N - 1);
            hold_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        state    <= GRANT;
                        sel      <= winner;
                        en       <= 1'b1;
                        grant    <= win_onehot;
                        busy     <= 1'b1;
                        hold_cnt <= HOLD_W'(1);
                    end
                end
                GRANT: begin
                    if (!arb_en || !req[sel] || hold_cnt == HOLD_MAX) begin
                        state   <= GAP;
                        en      <= 1'b0;
                        grant   <= '0;
                        last    <= sel;
                        gap_cnt <= GAP_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                GAP: begin
                    // The last gap edge arbitrates directly so a waiting requester loses no idle cycle.
                    if (gap_cnt == GAP_MAX) begin
                        if (win_valid) begin
                            state    <= GRANT;
                            sel      <= winner;
                            en       <= 1'b1;
                            grant    <= win_onehot;
                            hold_cnt <= HOLD_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    en    <= 1'b0;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// tb/tb_decoder_rr_scheduler.sv - directed and random checks of decoder_rr_scheduler against a burst-level model
module tb_decoder_rr_scheduler;
    localparam int SEL_W      = 3;
    localparam int MAX_HOLD   = 4;
    localparam int GAP_CYCLES = 1;
    localparam int N          = 2**SEL_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             arb_en;
    logic [N-1:0]     req;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic [N-1:0]     grant;
    logic             busy;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model: who holds the decoder, how long it has held it, gap left
    int m_owner;
    int m_used;
    int m_gap_left;
    int m_last;
    int m_sel;

    decoder_rr_scheduler #(
        .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en), .req(req),
        .sel(sel), .en(en), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int lst, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner    = -1;
        m_used     = 0;
        m_gap_left = 0;
        m_last     = N - 1;
        m_sel      = 0;
    endtask

    task automatic model_try_grant();
        int w;
        w = rr_pick(m_last, req);
        if (arb_en && w >= 0) begin
            m_owner = w;
            m_sel   = w;
            m_used  = 1;
        end
    endtask

    task automatic model_edge();
        if (m_owner >= 0) begin
            if (!arb_en || !req[m_owner] || m_used == MAX_HOLD) begin
                m_last     = m_owner;
                m_owner    = -1;
                m_gap_left = GAP_CYCLES;
            end else begin
                m_used++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
            if (m_gap_left == 0) model_try_grant();
        end else begin
            model_try_grant();
        end
    endtask

    task automatic compare_model();
        logic [N-1:0] g;
        g = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("sel", 32'(sel), 32'(m_sel));
        chk("en", 32'(en), 32'(m_owner >= 0));
        chk("grant", 32'(grant), 32'(g));
        chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_gap_left > 0)));
    endtask

    // Called with the bench parked at a negative edge.
    task automatic cyc(input logic [N-1:0] r, input logic a);
        req    = r;
        arb_en = a;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        arb_en = 1'b0;
        req    = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // reset mid-grant, then first grant goes to requester 0
        cyc(8'hFF, 1'b1);
        cyc(8'hFF, 1'b1);
        do_reset();
        cyc(8'hFF, 1'b1);
        chk("t1_first_sel", 32'(sel), 32'd0);
        chk("t1_first_en", 32'(en), 32'd1);

        // single requester repeats 4-on / 1-off
        do_reset();
        for (int i = 0; i < 15; i++) cyc(8'h08, 1'b1);

        // full round robin with wrap
        do_reset();
        for (int b = 0; b < 9; b++) begin
            cyc(8'hFF, 1'b1);
            chk("t3_rr_sel", 32'(sel), 32'(b % N));
            for (int i = 0; i < MAX_HOLD - 1; i++) cyc(8'hFF, 1'b1);
            cyc(8'hFF, 1'b1);
            chk("t3_gap_en", 32'(en), 32'd0);
        end

        // early release of requester 2
        do_reset();
        cyc(8'h24, 1'b1);
        chk("t4_sel2", 32'(sel), 32'd2);
        cyc(8'h24, 1'b1);
        cyc(8'h20, 1'b1);
        chk("t4_released", 32'(en), 32'd0);
        cyc(8'h20, 1'b1);
        chk("t4_next_sel", 32'(sel), 32'd5);

        // arb_en gating
        do_reset();
        for (int i = 0; i < 3; i++) cyc(8'hFF, 1'b0);
        cyc(8'hFF, 1'b1);
        cyc(8'hFF, 1'b1);
        cyc(8'hFF, 1'b0);
        chk("t5_drop_en", 32'(en), 32'd0);
        chk("t5_gap_busy", 32'(busy), 32'd1);

        // priority skip after last=6
        do_reset();
        for (int i = 0; i < MAX_HOLD; i++) cyc(8'h40, 1'b1);
        cyc(8'h41, 1'b1);
        cyc(8'h41, 1'b1);
        chk("t6_skip_sel", 32'(sel), 32'd0);
        for (int i = 0; i < MAX_HOLD; i++) cyc(8'h41, 1'b1);
        cyc(8'h41, 1'b1);
        chk("t6_next_sel", 32'(sel), 32'd6);

        // random traffic with occasional reset
        do_reset();
        begin
            logic [N-1:0] r;
            logic         a;
            r = '0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom & $urandom);
                a = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 299) == 0) do_reset();
                else cyc(r, a);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
